sram_line_controller: RTL and testbench
=======================================

// Module: sram_line_controller
// PURPOSE
//   Sequences the external 16-bit asynchronous SRAM on behalf of the 2-way data cache.
//   A cache miss (rd_en) becomes a 64-bit line fill: four halfword reads of the 8-byte-aligned block.
//   A write-through (wr_en) becomes two halfword writes of one 32-bit word.
//   ready is fed straight back to the cache as its sram_ready, so the cache samples read_data on that cycle.
// PARAMETERS
//   BASE_ADDR    32'd1024  data-memory base; physical byte offset = address - BASE_ADDR
//   SRAM_CYCLES  2         clocks per halfword access (>=2)
// PORTS
//   clk         in     1   system clock, all state on posedge
//   rst         in     1   asynchronous, active-low reset
//   rd_en       in     1   line-fill request (cache read_en2sram)
//   wr_en       in     1   word-write request (cache write_en2sram)
//   address     in     32  byte address of request
//   write_data  in     32  word to write
//   read_data   out    64  filled line, {hw3,hw2,hw1,hw0}; hw0 = lowest halfword address
//   ready       out    1   access complete / controller idle (see BEHAVIOUR)
//   SRAM_DQ     inout  16  SRAM data bus; driven only in WRITE states, else 16'bz
//   SRAM_ADDR   out    18  SRAM halfword address
//   SRAM_WE_N   out    1   write enable, active-low
//   SRAM_OE_N   out    1   output enable, active-low
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1  tied 0 (chip and both byte lanes always enabled)
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, phase/counter=0, read_data=0, SRAM_WE_N=1, SRAM_OE_N=1,
//     SRAM_ADDR=0, DQ released. Reset mid-access aborts the access; no ready pulse is produced.
//   - States: IDLE, READ, WRITE, DONE. 2-bit phase k, cycle counter c in 0..SRAM_CYCLES-1.
//   - off = address - BASE_ADDR (32-bit wrap). Only off[18:1] is used; higher bits are ignored.
//   - Request is sampled only in IDLE. If wr_en=1, go to WRITE (write has priority, even when rd_en=1).
//     Else if rd_en=1, go to READ. k=0 and c=0 on entry. address/write_data are latched on entry.
//   - READ: SRAM_ADDR={off[18:3],2'b00}+k. SRAM_OE_N=0 for every READ cycle.
//     On c=SRAM_CYCLES-1, capture SRAM_DQ into read_data[16k+15:16k]. k=3 then goes to DONE, else k++.
//     read_data keeps its other halfwords until overwritten.
//   - WRITE: SRAM_ADDR={off[18:2],1'b0}+k. DQ=write_data[16k+15:16k] for the whole phase.
//     SRAM_WE_N=0 for c<SRAM_CYCLES-1 and 1 on the last cycle, giving address/data hold.
//     Phase k=1 done then DONE.
//   - DONE: lasts exactly 1 cycle, ready=1, then IDLE. The requester drops rd_en/wr_en in this cycle.
//     A request still high in IDLE afterwards starts a new access.
//   - ready (combinational):
//       1 in DONE; 1 in IDLE when rd_en=0 and wr_en=0.
//       0 in IDLE with a pending request, and 0 in READ and WRITE.
//     Post-reset with no request: ready=1.
//   - Latency: the read pulses ready 4*SRAM_CYCLES+1 clocks after the sampling edge; the write pulses after 2*SRAM_CYCLES+1.
//   - read_data is stable from DONE until the next READ capture.
//   - No bus contention: OE_N=1 whenever DQ is driven, and WE_N=1 in every non-WRITE state.
// TESTING
//   1 Line fill: SRAM hw@0..3 = 1111,2222,3333,4444. rd_en at address 0x400, defaults ->
//     ready low 8 cycles, then DONE with read_data=64'h4444_3333_2222_1111 and SRAM_ADDR sequence 0,1,2,3.
//   2 Alignment: rd_en at 0x40C -> reads SRAM_ADDR 4..7 and returns that block.
//     Then wr_en at 0x40C with data 0xDEADBEEF -> hw6=BEEF, hw7=DEAD.
//     The bench checks the WE_N pulse width is 1 clock per phase and that DQ is Z outside WRITE.
//   3 rd_en and wr_en together -> WRITE runs first (ready after 5 clocks).
//     The held rd_en then starts a READ on the cycle after DONE.
//   4 Reset asserted at READ phase k=2 -> immediate IDLE, read_data=0, no ready pulse.
//     The bench checks outputs are inactive before any clock edge.
//   5 Back-to-back reads of different lines, each dropped in DONE -> exactly one ready pulse per access.
//     The second access must not see the first line's data.
//   6 SRAM_CYCLES=3 -> read ready after 13 clocks, write ready after 7, each WE_N low pulse is 2 clocks.

Source files
------------

// File: rtl/sram_line_controller.sv
// Sequences a 16-bit asynchronous SRAM for the data cache.
// A read fills a 64-bit line with four halfword reads. A write stores one 32-bit word as two halfwords.
module sram_line_controller #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          SRAM_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rd_en_i,
   input  logic        wr_en_i,
   input  logic [31:0] address_i,
   input  logic [31:0] write_data_i,
   output logic [63:0] read_data_o,
   output logic        ready_o,
   inout  wire  [15:0] sram_dq_io,
   output logic [17:0] sram_addr_o,
   output logic        sram_we_n_o,
   output logic        sram_oe_n_o,
   output logic        sram_ce_n_o,
   output logic        sram_ub_n_o,
   output logic        sram_lb_n_o
);

   localparam int            CW   = $clog2(SRAM_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(SRAM_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [17:0] hwAddr_q, hwAddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;

   logic [31:0] offset;
   logic        lastCycle;
   logic        dqDrive;
   logic [15:0] dqOut;
   logic        unusedOffsetBits;

   // Only halfword-address bits of the offset reach the SRAM.
   assign offset           = address_i - BASE_ADDR;
   assign unusedOffsetBits = ^{offset[31:19], offset[0]};
   assign lastCycle        = (cnt_q == LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         phase_q  <= 2'd0;
         cnt_q    <= '0;
         hwAddr_q <= 18'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 64'd0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         hwAddr_q <= hwAddr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      hwAddr_d = hwAddr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (wr_en_i || rd_en_i) begin
               state_d  = wr_en_i ? WRITE : READ;
               phase_d  = 2'd0;
               cnt_d    = '0;
               hwAddr_d = offset[18:1];
               wdata_d  = write_data_i;
            end
         end
         READ: begin
            if (lastCycle) begin
               rdata_d[16*phase_q +: 16] = sram_dq_io;
               cnt_d = '0;
               if (phase_q == 2'd3) begin
                  state_d = DONE;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WRITE: begin
            if (lastCycle) begin
               cnt_d = '0;
               if (phase_q == 2'd1) begin
                  state_d = DONE;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // WE_N rises on the last cycle of each write phase so address and data are held past it.
   always_comb begin
      sram_addr_o = 18'd0;
      sram_we_n_o = 1'b1;
      sram_oe_n_o = 1'b1;
      ready_o     = 1'b0;
      dqDrive     = 1'b0;
      dqOut       = 16'd0;
      case (state_q)
         IDLE: begin
            ready_o = !rd_en_i && !wr_en_i;
         end
         READ: begin
            sram_addr_o = {hwAddr_q[17:2], 2'b00} + {16'd0, phase_q};
            sram_oe_n_o = 1'b0;
         end
         WRITE: begin
            sram_addr_o = {hwAddr_q[17:1], 1'b0} + {16'd0, phase_q};
            sram_we_n_o = lastCycle;
            dqDrive     = 1'b1;
            dqOut       = phase_q[0] ? wdata_q[31:16] : wdata_q[15:0];
         end
         DONE: begin
            ready_o = 1'b1;
         end
         default: begin
            ready_o = 1'b0;
         end
      endcase
   end

   assign sram_dq_io  = dqDrive ? dqOut : 16'bz;
   assign read_data_o = rdata_q;
   assign sram_ce_n_o = 1'b0;
   assign sram_ub_n_o = 1'b0;
   assign sram_lb_n_o = 1'b0;

endmodule

// File: tb/tb_sram_line_controller.sv
// Bench for sram_line_controller: two instances (2 and 3 clocks per access) against an array SRAM
// and a reference memory that derives expected line contents and bus addresses arithmetically.
module tb_sram_line_controller;

   logic        clk = 1'b0;
   logic        rstN;
   logic        rd [2];
   logic        wr [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   wire  [63:0] rdata [2];
   wire         ready [2];
   wire  [17:0] sAddr [2];
   wire         weN [2];
   wire         oeN [2];
   wire         ceN [2];
   wire         ubN [2];
   wire         lbN [2];
   wire  [15:0] dq0;
   wire  [15:0] dq1;

   logic [15:0] sram   [2][262144];
   logic [15:0] refMem [2][262144];

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   sram_line_controller #(.BASE_ADDR(32'd1024), .SRAM_CYCLES(2)) u0 (
      .clk_i(clk), .rst_ni(rstN), .rd_en_i(rd[0]), .wr_en_i(wr[0]),
      .address_i(addr[0]), .write_data_i(wdata[0]), .read_data_o(rdata[0]),
      .ready_o(ready[0]), .sram_dq_io(dq0), .sram_addr_o(sAddr[0]),
      .sram_we_n_o(weN[0]), .sram_oe_n_o(oeN[0]), .sram_ce_n_o(ceN[0]),
      .sram_ub_n_o(ubN[0]), .sram_lb_n_o(lbN[0])
   );

   sram_line_controller #(.BASE_ADDR(32'd1024), .SRAM_CYCLES(3)) u1 (
      .clk_i(clk), .rst_ni(rstN), .rd_en_i(rd[1]), .wr_en_i(wr[1]),
      .address_i(addr[1]), .write_data_i(wdata[1]), .read_data_o(rdata[1]),
      .ready_o(ready[1]), .sram_dq_io(dq1), .sram_addr_o(sAddr[1]),
      .sram_we_n_o(weN[1]), .sram_oe_n_o(oeN[1]), .sram_ce_n_o(ceN[1]),
      .sram_ub_n_o(ubN[1]), .sram_lb_n_o(lbN[1])
   );

   // The SRAM drives the bus only while output enable is asserted.
   assign dq0 = (oeN[0] == 1'b0) ? sram[0][sAddr[0]] : 16'bz;
   assign dq1 = (oeN[1] == 1'b0) ? sram[1][sAddr[1]] : 16'bz;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int lineBase(input logic [31:0] a);
      logic [31:0] o;
      o = (a - 32'd1024) & 32'h0007_FFFF;
      return int'(o / 8) * 4;
   endfunction

   function automatic int wordBase(input logic [31:0] a);
      logic [31:0] o;
      o = (a - 32'd1024) & 32'h0007_FFFF;
      return int'(o / 4) * 2;
   endfunction

   function automatic logic [63:0] refLine(input int sel, input int b);
      return {refMem[sel][b+3], refMem[sel][b+2], refMem[sel][b+1], refMem[sel][b]};
   endfunction

   // Called at a negedge while the selected controller is idle; returns at the negedge after DONE.
   task automatic applyStimulus(input int sel, input bit doWr, input bit doRd,
                                input logic [31:0] a, input logic [31:0] d, input bit keepRd);
      int c;
      int total;
      int base;
      logic [63:0] expLine;
      logic [15:0] dqv;
      c = (sel == 0) ? 2 : 3;
      addr[sel]  = a;
      wdata[sel] = d;
      wr[sel]    = doWr;
      rd[sel]    = doRd;
      #1;
      checkOutput("pendReady", 64'(ready[sel]), 64'd0);
      base = doWr ? wordBase(a) : lineBase(a);
      if (doWr) begin
         refMem[sel][base]   = d[15:0];
         refMem[sel][base+1] = d[31:16];
      end
      total = (doWr ? 2 : 4) * c;
      for (int n = 1; n <= total; n++) begin
         @(negedge clk);
         checkOutput("busyReady", 64'(ready[sel]), 64'd0);
         checkOutput("sramAddr", 64'(sAddr[sel]), 64'(base + (n - 1) / c));
         checkOutput("oeN", 64'(oeN[sel]), 64'(doWr));
         checkOutput("weN", 64'(weN[sel]), 64'((doWr && ((n - 1) % c != c - 1)) ? 0 : 1));
         dqv = (sel == 0) ? dq0 : dq1;
         if (weN[sel] == 1'b0) sram[sel][sAddr[sel]] = dqv;
      end
      @(negedge clk);
      checkOutput("doneReady", 64'(ready[sel]), 64'd1);
      expLine = refLine(sel, lineBase(a));
      if (!doWr) checkOutput("lineData", rdata[sel], expLine);
      wr[sel] = 1'b0;
      rd[sel] = keepRd;
      @(negedge clk);
      checkOutput("afterDone", 64'(ready[sel]), 64'(!keepRd));
      if (!doWr) checkOutput("lineHold", rdata[sel], expLine);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      bit          rw;
      int          rs;
      rstN = 1'b0;
      for (int s = 0; s < 2; s++) begin
         rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'd0; wdata[s] = 32'd0;
         for (int i = 0; i < 262144; i++) begin
            sram[s][i]   = 16'($urandom);
            refMem[s][i] = sram[s][i];
         end
      end
      #1;
      for (int s = 0; s < 2; s++) begin
         checkOutput("rstReady", 64'(ready[s]), 64'd1);
         checkOutput("rstData", rdata[s], 64'd0);
         checkOutput("rstWeN", 64'(weN[s]), 64'd1);
         checkOutput("rstOeN", 64'(oeN[s]), 64'd1);
         checkOutput("rstAddr", 64'(sAddr[s]), 64'd0);
         checkOutput("tieOffs", 64'({ceN[s], ubN[s], lbN[s]}), 64'd0);
      end
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);

      $display("[TB] line fill at 0x400");
      for (int i = 0; i < 4; i++) begin
         sram[0][i]   = 16'h1111 * 16'(i + 1);
         refMem[0][i] = sram[0][i];
      end
      applyStimulus(0, 1'b0, 1'b1, 32'h400, 32'd0, 1'b0);
      checkOutput("fillValue", rdata[0], 64'h4444_3333_2222_1111);

      $display("[TB] alignment at 0x40C");
      applyStimulus(0, 1'b0, 1'b1, 32'h40C, 32'd0, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 32'h40C, 32'hDEAD_BEEF, 1'b0);
      checkOutput("hw6", 64'(sram[0][6]), 64'h0000_BEEF);
      checkOutput("hw7", 64'(sram[0][7]), 64'h0000_DEAD);
      applyStimulus(0, 1'b0, 1'b1, 32'h408, 32'd0, 1'b0);

      $display("[TB] simultaneous read and write");
      applyStimulus(0, 1'b1, 1'b1, 32'h420, 32'h1234_5678, 1'b1);
      applyStimulus(0, 1'b0, 1'b1, 32'h420, 32'd0, 1'b0);

      $display("[TB] back-to-back reads");
      applyStimulus(0, 1'b0, 1'b1, 32'h500, 32'd0, 1'b0);
      applyStimulus(0, 1'b0, 1'b1, 32'h588, 32'd0, 1'b0);

      $display("[TB] reset during read phase 2");
      rd[0]   = 1'b1;
      addr[0] = 32'h440;
      repeat (5) @(negedge clk);
      checkOutput("phase2Addr", 64'(sAddr[0]), 64'(lineBase(32'h440) + 2));
      rstN = 1'b0;
      #1;
      checkOutput("abortReady", 64'(ready[0]), 64'd0);
      checkOutput("abortData", rdata[0], 64'd0);
      checkOutput("abortOeN", 64'(oeN[0]), 64'd1);
      checkOutput("abortWeN", 64'(weN[0]), 64'd1);
      checkOutput("abortAddr", 64'(sAddr[0]), 64'd0);
      rd[0] = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("postAbortReady", 64'(ready[0]), 64'd1);
         checkOutput("postAbortData", rdata[0], 64'd0);
      end

      $display("[TB] three clocks per access");
      applyStimulus(1, 1'b0, 1'b1, 32'h400, 32'd0, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 32'h404, 32'hCAFE_F00D, 1'b0);
      applyStimulus(1, 1'b0, 1'b1, 32'h400, 32'd0, 1'b0);

      $display("[TB] randomized accesses");
      for (int i = 0; i < 40; i++) begin
         rs = int'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'h400 + 32'($urandom_range(0, 255));
         applyStimulus(rs, rw, rw ? 1'($urandom_range(0, 1)) : 1'b1, ra, $urandom, 1'b0);
         if (rw) applyStimulus(rs, 1'b0, 1'b1, ra, 32'd0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
